bsa_sum_collector: RTL and testbench

- Downstream stage of the bit-serial adder (BSA): captures its LSB-first serial sum output `sbit` and reassembles it into a parallel (WL+1)-bit word, including the final carry.
- Presents the word with a one-cycle `Valid` pulse to the parallel datapath.
- Shares the adder's `Load`-style start strobe, so a single control line drives both blocks.

---
 rtl/bsa_pkg.sv | 28 ++
 rtl/sipo_shreg.sv | 31 +++
 rtl/bsa_sum_collector.sv | 105 ++++++++++
 tb/tb_bsa_sum_collector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder family: word sizes, the
// collector state encoding and a constant log2 helper.
package bsa_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BSA_WL    = 4;
  localparam int BSA_NBITS = BSA_WL + 1;

  // Serial result width: WL sum bits plus the carry-out.
  function automatic int nbits(input int wl);
    return wl + 1;
  endfunction

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in/parallel-out shift register, LSB first: new bits enter at the MSB
// and move right, so after WIDTH shifts the first bit sits at bit 0.
module sipo_shreg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // par_o is the word as it will be after this cycle's shift, so the
  // consumer can capture the completed word on the same edge as the last bit.
  assign shreg_d = {sin_i, shreg_q[WIDTH-1:1]};
  assign par_o   = shreg_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      shreg_q <= '0;
    end else if (en_i) begin
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/bsa_sum_collector.sv
// Collects the LSB-first serial sum of the bit-serial adder into a parallel
// (WL+1)-bit word and flags each completed word with a one-cycle Valid pulse.
module bsa_sum_collector
  import bsa_pkg::*;
#(
  parameter int WL = BSA_WL
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        sbit,
  output logic [WL:0] Sum,
  output logic        Valid,
  output logic        Busy,
  output logic        Cout
);

  localparam int NBITS = nbits(WL);
  localparam int CNT_W = clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               valid_q, valid_d;

  logic               shift_en;
  logic               frame_clr_n;
  logic               shreg_clr_n;
  logic [NBITS-1:0]   shreg_next;

  // The shift register is cleared both by reset and when a new frame is
  // accepted, so a stale partial word can never leak into the next result.
  assign shreg_clr_n = RST & frame_clr_n;

  sipo_shreg #(
    .WIDTH (NBITS)
  ) u_sipo (
    .clk     (CLK),
    .clr_n_i (shreg_clr_n),
    .en_i    (shift_en),
    .sin_i   (sbit),
    .par_o   (shreg_next)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    valid_d     = 1'b0;
    shift_en    = 1'b0;
    frame_clr_n = 1'b1;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = SHIFT;
          cnt_d       = '0;
          frame_clr_n = 1'b0;
        end
      end

      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          sum_d   = shreg_next;
          cout_d  = sbit;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign Valid = valid_q;
  assign Busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_bsa_sum_collector.sv
// Directed bench for bsa_sum_collector: serial frames driven directly, then a
// frame produced by a small bit-serial adder model chained in front.
module tb_bsa_sum_collector;

  localparam int WL    = 4;
  localparam int NBITS = WL + 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Start;
  logic             sbit;
  logic [NBITS-1:0] Sum;
  logic             Valid;
  logic             Busy;
  logic             Cout;

  logic             sbit_drv;
  logic             use_bsa;
  logic [WL-1:0]    load_a, load_b;
  logic [WL-1:0]    bsa_a_q, bsa_b_q;
  logic             bsa_c_q;

  int checks   = 0;
  int failures = 0;

  bsa_sum_collector #(
    .WL (WL)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .sbit  (sbit),
    .Sum   (Sum),
    .Valid (Valid),
    .Busy  (Busy),
    .Cout  (Cout)
  );

  always #5 CLK = ~CLK;

  // Bit-serial adder model: loads on Start, then emits a^b^c LSB first; once
  // both operands have shifted out the emitted bit is the final carry.
  always @(posedge CLK) begin
    if (Start) begin
      bsa_a_q <= load_a;
      bsa_b_q <= load_b;
      bsa_c_q <= 1'b0;
    end else begin
      bsa_a_q <= bsa_a_q >> 1;
      bsa_b_q <= bsa_b_q >> 1;
      bsa_c_q <= (bsa_a_q[0] & bsa_b_q[0]) | (bsa_a_q[0] & bsa_c_q) | (bsa_b_q[0] & bsa_c_q);
    end
  end

  assign sbit = use_bsa ? (bsa_a_q[0] ^ bsa_b_q[0] ^ bsa_c_q) : sbit_drv;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; sbit_drv = 1'bx; use_bsa = 1'b0;
    load_a = '0; load_b = '0;
    tick(); tick();
    checks++;
    if ({Sum, Valid, Busy, Cout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got Sum=%b V=%b B=%b C=%b exp all zero", Sum, Valid, Busy, Cout);
    end
    RST = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({Sum, Valid, Busy, Cout} !== 8'h00) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got Sum=%b V=%b B=%b C=%b exp all zero", c, Sum, Valid, Busy, Cout);
      end
    end
  endtask

  task automatic test_full_add();
    logic [NBITS-1:0] bits;
    bits = 5'b11110;
    Start = 1'b1; sbit_drv = 1'bx;
    tick();
    Start = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      checks++;
      if (Busy !== 1'b1 || Valid !== 1'b0) begin
        failures++;
        $display("FAIL full_busy i=%0d got B=%b V=%b exp B=1 V=0", i, Busy, Valid);
      end
      sbit_drv = bits[i];
      tick();
    end
    sbit_drv = 1'bx;
    checks++;
    if (Valid !== 1'b1 || Busy !== 1'b0 || Sum !== 5'b11110 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL full_result got Sum=%b V=%b B=%b C=%b exp Sum=11110 V=1 B=0 C=1", Sum, Valid, Busy, Cout);
    end
    tick();
    checks++;
    if (Valid !== 1'b0 || Sum !== 5'b11110 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL full_hold got Sum=%b V=%b C=%b exp Sum=11110 V=0 C=1", Sum, Valid, Cout);
    end
  endtask

  task automatic test_restart_ignored();
    logic [NBITS-1:0] bits;
    bits = 5'b00101;
    Start = 1'b1; sbit_drv = 1'bx;
    tick();
    Start = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      Start    = (i == 2);
      sbit_drv = bits[i];
      tick();
      if (i < NBITS - 1) begin
        checks++;
        if (Busy !== 1'b1 || Valid !== 1'b0) begin
          failures++;
          $display("FAIL restart_busy i=%0d got B=%b V=%b exp B=1 V=0", i, Busy, Valid);
        end
      end
    end
    Start = 1'b0; sbit_drv = 1'bx;
    checks++;
    if (Valid !== 1'b1 || Sum !== 5'b00101 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL restart_result got Sum=%b V=%b C=%b exp Sum=00101 V=1 C=0", Sum, Valid, Cout);
    end
    tick();
    checks++;
    if (Valid !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_idle got V=%b B=%b exp V=0 B=0", Valid, Busy);
    end
  endtask

  task automatic test_reset_midframe();
    Start = 1'b1; sbit_drv = 1'bx;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sbit_drv = 1'b1;
      tick();
    end
    RST = 1'b0;
    tick();
    checks++;
    if ({Sum, Valid, Busy, Cout} !== 8'h00) begin
      failures++;
      $display("FAIL midreset_clear got Sum=%b V=%b B=%b C=%b exp all zero", Sum, Valid, Busy, Cout);
    end
    RST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (Valid !== 1'b0 || Busy !== 1'b0 || Sum !== 5'b00000) begin
        failures++;
        $display("FAIL midreset_novalid cyc=%0d got Sum=%b V=%b B=%b exp Sum=00000 V=0 B=0", c, Sum, Valid, Busy);
      end
    end
    Start = 1'b1; sbit_drv = 1'bx;
    tick();
    Start = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      sbit_drv = (i == NBITS - 1);
      tick();
    end
    sbit_drv = 1'bx;
    checks++;
    if (Valid !== 1'b1 || Sum !== 5'b10000 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL midreset_clean got Sum=%b V=%b C=%b exp Sum=10000 V=1 C=1", Sum, Valid, Cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NBITS-1:0] frames [2];
    logic [NBITS-1:0] exp_sum;
    int cyc;
    int vcyc [2];
    frames[0] = 5'b00001;
    frames[1] = 5'b00010;
    cyc = 0;
    Start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      sbit_drv = 1'bx;
      tick(); cyc++;
      checks++;
      if (Busy !== 1'b1 || Valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_accept f=%0d got B=%b V=%b exp B=1 V=0", f, Busy, Valid);
      end
      for (int i = 0; i < NBITS; i++) begin
        sbit_drv = frames[f][i];
        tick(); cyc++;
        if (i < NBITS - 1) begin
          checks++;
          if (Busy !== 1'b1 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy f=%0d i=%0d got B=%b V=%b exp B=1 V=0", f, i, Busy, Valid);
          end
        end
      end
      exp_sum = frames[f];
      vcyc[f] = cyc;
      checks++;
      if (Valid !== 1'b1 || Busy !== 1'b0 || Sum !== exp_sum) begin
        failures++;
        $display("FAIL b2b_result f=%0d got Sum=%b V=%b B=%b exp Sum=%b V=1 B=0", f, Sum, Valid, Busy, exp_sum);
      end
    end
    checks++;
    if (vcyc[1] - vcyc[0] !== 6) begin
      failures++;
      $display("FAIL b2b_spacing got %0d cycles exp 6", vcyc[1] - vcyc[0]);
    end
    Start = 1'b0; sbit_drv = 1'bx;
    tick();
    checks++;
    if (Valid !== 1'b1 && Busy !== 1'b1 && Valid === 1'b0 && Busy === 1'b0) begin
    end else begin
      failures++;
      $display("FAIL b2b_stop got V=%b B=%b exp V=0 B=0", Valid, Busy);
    end
  endtask

  task automatic test_chained_bsa();
    int vcount;
    use_bsa = 1'b1;
    load_a  = 4'b1001;
    load_b  = 4'b0111;
    Start   = 1'b1;
    tick();
    Start  = 1'b0;
    vcount = 0;
    for (int c = 1; c <= NBITS; c++) begin
      tick();
      if (c < NBITS) begin
        checks++;
        if (Valid !== 1'b0 || Busy !== 1'b1) begin
          failures++;
          $display("FAIL chain_wait c=%0d got V=%b B=%b exp V=0 B=1", c, Valid, Busy);
        end
      end
    end
    checks++;
    if (Valid !== 1'b1 || Sum !== 5'b10000 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL chain_result got Sum=%b V=%b C=%b exp Sum=10000 V=1 C=1", Sum, Valid, Cout);
    end
    tick();
    checks++;
    if (Valid !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL chain_idle got V=%b B=%b exp V=0 B=0", Valid, Busy);
    end
    use_bsa = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_add();
    test_restart_ignored();
    test_reset_midframe();
    test_back_to_back();
    test_chained_bsa();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
